tiny16_out_trace: RTL and testbench



---
 rtl/tiny16_trace_pkg.sv | 21 ++
 rtl/tiny16_out_trace_if.sv | 13 +
 rtl/tiny16_trace_fifo.sv | 78 +++++++
 rtl/tiny16_out_trace.sv | 129 ++++++++++++
 tb/tb_tiny16_out_trace.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/tiny16_trace_pkg.sv
// Shared types for the tiny16 OUT-port trace capture: FSM states and default entry layout.
package tiny16_trace_pkg;

    localparam int unsigned TRACE_DATA_W     = 16;
    localparam int unsigned TRACE_TS_W       = 16;
    localparam int unsigned TRACE_DEPTH      = 16;
    localparam int unsigned TRACE_IDLE_LIMIT = 256;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } trace_state_t;

    // Entry layout at the default widths; the top re-declares it with its own parameters.
    typedef struct packed {
        logic [TRACE_DATA_W-1:0] data;
        logic [TRACE_TS_W-1:0]   ts;
    } trace_entry_t;

endpackage

// File: rtl/tiny16_out_trace_if.sv
// Valid/ready readout channel of the trace buffer: head value plus its timestamp.
interface tiny16_out_trace_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned TS_W   = 16
);
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic [TS_W-1:0]   rd_ts;

    modport master (output rd_valid, output rd_data, output rd_ts, input rd_ready);
    modport slave  (input rd_valid, input rd_data, input rd_ts, output rd_ready);
endinterface

// File: rtl/tiny16_trace_fifo.sv
// Circular trace buffer with registered head output and optional overwrite-on-full.
// TINY16_TRACE_OVF_CNT_EN adds the ovf_c pulse (entry dropped or overwritten).
module tiny16_trace_fifo #(
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WRAP  = 0,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             we,
    input  logic [W-1:0]     wdata,
    input  logic             rd_ready,
    output logic             rd_valid,
    output logic [W-1:0]     rd_entry,
`ifdef TINY16_TRACE_OVF_CNT_EN
    output logic             ovf_c,
`endif
    output logic [CNT_W-1:0] count
);
    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam bit          WRAP_EN = (WRAP != 0);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] head, tail, head_nxt, tail_nxt;
    logic [CNT_W-1:0] count_nxt;
    logic [W-1:0]     head_data_c;
    logic             pop_c, full_c, wr_c, ovw_c;

    // Pointer/count update; a pop frees a slot so a full buffer never drops on pop+write.
    always_comb begin
        pop_c     = rd_valid && rd_ready;
        full_c    = (count == CNT_W'(DEPTH));
        wr_c      = we && (!full_c || pop_c || WRAP_EN);
        ovw_c     = we && full_c && !pop_c && WRAP_EN;
        head_nxt  = head;
        tail_nxt  = tail;
        count_nxt = count;
        if (wr_c)
            tail_nxt = tail + PTR_W'(1);
        if (pop_c || ovw_c)
            head_nxt = head + PTR_W'(1);
        if (wr_c && !pop_c && !ovw_c)
            count_nxt = count + CNT_W'(1);
        else if (pop_c && !wr_c)
            count_nxt = count - CNT_W'(1);
        head_data_c = (wr_c && (tail == head_nxt)) ? wdata : mem[head_nxt];
    end

`ifdef TINY16_TRACE_OVF_CNT_EN
    assign ovf_c = we && full_c && !pop_c;
`endif

    always_ff @(posedge clk) begin
        if (wr_c)
            mem[tail] <= wdata;
    end

    // Head output register is loaded with the post-edge head entry.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            rd_valid <= 1'b0;
            rd_entry <= '0;
        end else begin
            head     <= head_nxt;
            tail     <= tail_nxt;
            count    <= count_nxt;
            rd_valid <= (count_nxt != '0);
            if (count_nxt != '0)
                rd_entry <= head_data_c;
        end
    end

endmodule

// File: rtl/tiny16_out_trace.sv
// Passive capture of every tiny16 OUT change with a cycle timestamp, ended by stop or idle watchdog.
// TINY16_TRACE_OVF_CNT_EN adds the ovf_cnt output counting dropped/overwritten entries.
module tiny16_out_trace
    import tiny16_trace_pkg::*;
#(
    parameter int unsigned DATA_W     = TRACE_DATA_W,
    parameter int unsigned DEPTH      = TRACE_DEPTH,
    parameter int unsigned TS_W       = TRACE_TS_W,
    parameter int unsigned IDLE_LIMIT = TRACE_IDLE_LIMIT,
    parameter int unsigned WRAP       = 0
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     start,
    input  logic                     stop,
    input  logic [DATA_W-1:0]        obs,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH):0]   count,
`ifdef TINY16_TRACE_OVF_CNT_EN
    output logic [TS_W-1:0]          ovf_cnt,
`endif
    tiny16_out_trace_if.master       rd
);
    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
    localparam int unsigned ENTRY_W = DATA_W + TS_W;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [TS_W-1:0]   ts;
    } entry_t;

    trace_state_t      state, state_nxt;
    logic [TS_W-1:0]   ts, idle;
    logic [DATA_W-1:0] prev;
    logic              first;
    logic              enter_c, in_cap_c, limit_c, we_c;
    entry_t            wentry_c, rentry;

    always_ff @(posedge CLK) begin
        if (RST)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next state, change detect and watchdog; the watchdog cycle never writes.
    always_comb begin
        state_nxt = state;
        enter_c   = 1'b0;
        in_cap_c  = (state == CAPTURE);
        limit_c   = in_cap_c && (idle == TS_W'(IDLE_LIMIT));
        we_c      = in_cap_c && !limit_c && (first || (obs != prev));
        wentry_c  = '{data: obs, ts: ts};
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = CAPTURE;
                    enter_c   = 1'b1;
                end
            end
            CAPTURE: begin
                if (stop || limit_c)
                    state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            busy  <= 1'b0;
            done  <= 1'b0;
            ts    <= '0;
            idle  <= '0;
            prev  <= '0;
            first <= 1'b0;
        end else begin
            busy <= (state_nxt == CAPTURE);
            done <= (state_nxt == DONE);
            if (enter_c) begin
                ts    <= '0;
                idle  <= '0;
                first <= 1'b1;
            end else if (in_cap_c) begin
                first <= 1'b0;
                prev  <= obs;
                if (ts != '1)
                    ts <= ts + TS_W'(1);
                idle <= we_c ? '0 : idle + TS_W'(1);
            end
        end
    end

`ifdef TINY16_TRACE_OVF_CNT_EN
    logic ovf_c;

    always_ff @(posedge CLK) begin
        if (RST || enter_c)
            ovf_cnt <= '0;
        else if (ovf_c && (ovf_cnt != '1))
            ovf_cnt <= ovf_cnt + TS_W'(1);
    end
`endif

    tiny16_trace_fifo #(
        .W     (ENTRY_W),
        .DEPTH (DEPTH),
        .WRAP  (WRAP),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk      (CLK),
        .rst      (RST),
        .clear    (enter_c),
        .we       (we_c),
        .wdata    (wentry_c),
        .rd_ready (rd.rd_ready),
        .rd_valid (rd.rd_valid),
        .rd_entry (rentry),
`ifdef TINY16_TRACE_OVF_CNT_EN
        .ovf_c    (ovf_c),
`endif
        .count    (count)
    );

    assign rd.rd_data = rentry.data;
    assign rd.rd_ts   = rentry.ts;

endmodule

// File: tb/tb_tiny16_out_trace.sv
// Directed bench: three trace instances (16-deep drop, 4-deep drop, 4-deep wrap) on shared stimulus.
module tb_tiny16_out_trace;

    logic        CLK = 1'b0;
    logic        RST;
    logic        start, stop;
    logic [15:0] obs;

    logic       busy_a, done_a, busy_b, done_b, busy_c, done_c;
    logic [4:0] count_a;
    logic [2:0] count_b, count_c;
`ifdef TINY16_TRACE_OVF_CNT_EN
    logic [15:0] ovf_a, ovf_b, ovf_c;
`endif

    int errors = 0;
    int checks = 0;

    tiny16_out_trace_if #(.DATA_W(16), .TS_W(16)) ifa ();
    tiny16_out_trace_if #(.DATA_W(16), .TS_W(16)) ifb ();
    tiny16_out_trace_if #(.DATA_W(16), .TS_W(16)) ifc ();

    tiny16_out_trace #(.DEPTH(16), .WRAP(0)) u_a (
        .CLK(CLK), .RST(RST), .start(start), .stop(stop), .obs(obs),
        .busy(busy_a), .done(done_a), .count(count_a),
`ifdef TINY16_TRACE_OVF_CNT_EN
        .ovf_cnt(ovf_a),
`endif
        .rd(ifa)
    );

    tiny16_out_trace #(.DEPTH(4), .WRAP(0)) u_b (
        .CLK(CLK), .RST(RST), .start(start), .stop(stop), .obs(obs),
        .busy(busy_b), .done(done_b), .count(count_b),
`ifdef TINY16_TRACE_OVF_CNT_EN
        .ovf_cnt(ovf_b),
`endif
        .rd(ifb)
    );

    tiny16_out_trace #(.DEPTH(4), .WRAP(1)) u_c (
        .CLK(CLK), .RST(RST), .start(start), .stop(stop), .obs(obs),
        .busy(busy_c), .done(done_c), .count(count_c),
`ifdef TINY16_TRACE_OVF_CNT_EN
        .ovf_cnt(ovf_c),
`endif
        .rd(ifc)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock; inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_ready(input logic r);
        ifa.rd_ready = r;
        ifb.rd_ready = r;
        ifc.rd_ready = r;
    endtask

    logic [31:0] popped[$];

    task automatic hold(input int n);
        for (int k = 0; k < n; k++) begin
            if (ifa.rd_valid && ifa.rd_ready)
                popped.push_back({ifa.rd_data, ifa.rd_ts});
            step();
        end
    endtask

    logic [15:0] vals [6] = '{16'h0A01, 16'h0A02, 16'h0A03, 16'h0A04, 16'h0A05, 16'h0A06};
    logic [15:0] wv   [5] = '{16'h0B00, 16'h0B11, 16'h0B22, 16'h0B33, 16'h0B44};

    initial begin
        int n;
        logic [31:0] e;
        RST = 1'b1; start = 1'b0; stop = 1'b0; obs = 16'h0000;
        set_ready(1'b0);
        step(); step();
        check("rst_busy",     64'(busy_a), 64'd0);
        check("rst_done",     64'(done_a), 64'd0);
        check("rst_count",    64'(count_a), 64'd0);
        check("rst_rd_valid", 64'(ifa.rd_valid), 64'd0);
        check("rst_rd_data",  64'(ifa.rd_data), 64'd0);
        check("rst_rd_ts",    64'(ifa.rd_ts), 64'd0);
        RST = 1'b0;

        // Steady obs: one entry at ts 0, watchdog ends capture 257 cycles after the first write.
        start = 1'b1; step(); start = 1'b0;
        check("start_busy", 64'(busy_a), 64'd1);
        step();
        check("first_count", 64'(count_a), 64'd1);
        check("first_valid", 64'(ifa.rd_valid), 64'd1);
        check("first_ts",    64'(ifa.rd_ts), 64'd0);
        n = 0;
        while (!done_a && n < 400) begin
            step();
            n++;
        end
        check("idle_done_cycle", 64'(n), 64'd257);
        check("idle_busy",       64'(busy_a), 64'd0);
        check("idle_count",      64'(count_a), 64'd1);
        check("idle_data",       64'(ifa.rd_data), 64'd0);
        set_ready(1'b1); step();
        check("idle_drained", 64'(count_a), 64'd0);
        check("idle_valid0",  64'(ifa.rd_valid), 64'd0);

        // 1,2,3 held 3 cycles each, read while capturing.
        obs = 16'h0001; start = 1'b1; step(); start = 1'b0;
        hold(3);
        obs = 16'h0002; hold(3);
        obs = 16'h0003; hold(3);
        hold(3);
        check("seq_n", 64'(popped.size()), 64'd3);
        for (int k = 0; k < 3; k++) begin
            e = (k < popped.size()) ? popped[k] : 32'hFFFF_FFFF;
            check($sformatf("seq_data%0d", k), 64'(e[31:16]), 64'(k + 1));
            check($sformatf("seq_ts%0d", k),   64'(e[15:0]),  64'(3 * k));
        end
        check("seq_count0", 64'(count_a), 64'd0);
        stop = 1'b1; step(); stop = 1'b0;
        check("seq_stop_done", 64'(done_a), 64'd1);

        // Six entries into 4-deep buffers, no reads.
        set_ready(1'b0);
        obs = vals[0]; start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            obs = vals[i];
            step();
        end
        check("ovf_count_a", 64'(count_a), 64'd6);
        check("ovf_count_b", 64'(count_b), 64'd4);
        check("ovf_count_c", 64'(count_c), 64'd4);
`ifdef TINY16_TRACE_OVF_CNT_EN
        check("ovf_cnt_a", 64'(ovf_a), 64'd0);
        check("ovf_cnt_b", 64'(ovf_b), 64'd2);
        check("ovf_cnt_c", 64'(ovf_c), 64'd2);
`endif
        stop = 1'b1; step(); stop = 1'b0;
        ifb.rd_ready = 1'b1; ifc.rd_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("drop_data%0d", k), 64'(ifb.rd_data), 64'(vals[k]));
            check($sformatf("wrap_data%0d", k), 64'(ifc.rd_data), 64'(vals[k + 2]));
            check($sformatf("wrap_ts%0d", k),   64'(ifc.rd_ts),   64'(k + 2));
            step();
        end
        check("drop_empty", 64'(ifb.rd_valid), 64'd0);
        check("wrap_empty", 64'(count_c), 64'd0);

        // Full buffer with pop and change on the same edge.
        set_ready(1'b0);
        obs = wv[0]; start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            obs = wv[i];
            step();
        end
        check("full_count_b", 64'(count_b), 64'd4);
        ifb.rd_ready = 1'b1; ifc.rd_ready = 1'b1; obs = wv[4];
        step();
        set_ready(1'b0);
        check("popw_count_b", 64'(count_b), 64'd4);
        check("popw_count_c", 64'(count_c), 64'd4);
`ifdef TINY16_TRACE_OVF_CNT_EN
        check("popw_ovf_b", 64'(ovf_b), 64'd0);
        check("popw_ovf_c", 64'(ovf_c), 64'd0);
`endif
        check("popw_hold_b", 64'(ifb.rd_data), 64'(wv[1]));
        step();
        check("popw_stable_b", 64'(ifb.rd_data), 64'(wv[1]));
        stop = 1'b1; step(); stop = 1'b0;
        ifb.rd_ready = 1'b1; ifc.rd_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("popw_b%0d", k),    64'(ifb.rd_data), 64'(wv[k + 1]));
            check($sformatf("popw_b_ts%0d", k), 64'(ifb.rd_ts),   64'(k + 1));
            check($sformatf("popw_c%0d", k),    64'(ifc.rd_data), 64'(wv[k + 1]));
            step();
        end
        set_ready(1'b0);

        // Reset mid-capture, fresh capture, then stop coinciding with a change.
        obs = 16'h0C00; start = 1'b1; step(); start = 1'b0;
        obs = 16'h0C00; step();
        obs = 16'h0C01; step();
        obs = 16'h0C02; step();
        check("mid_count", 64'(count_a), 64'd3);
        RST = 1'b1; step(); RST = 1'b0;
        check("mid_rst_busy",  64'(busy_a), 64'd0);
        check("mid_rst_done",  64'(done_a), 64'd0);
        check("mid_rst_count", 64'(count_a), 64'd0);
        check("mid_rst_valid", 64'(ifa.rd_valid), 64'd0);
        obs = 16'h0C09; start = 1'b1; step(); start = 1'b0;
        step();
        check("fresh_count", 64'(count_a), 64'd1);
        check("fresh_data",  64'(ifa.rd_data), 64'h0C09);
        check("fresh_ts",    64'(ifa.rd_ts), 64'd0);
        obs = 16'h0C0A; stop = 1'b1; step(); stop = 1'b0;
        check("stopchg_count", 64'(count_a), 64'd2);
        check("stopchg_done",  64'(done_a), 64'd1);
        check("stopchg_busy",  64'(busy_a), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
